alu_seq: RTL and testbench

Parametrised multi-cycle successor to the datapath ALU. Adds XOR, signed set-less-than, iterative unsigned multiply and divide, registered outputs, a full NZCV-style flag set and a start/ready/done handshake. Sits in the execute stage. The control unit stalls on ready=0 and consumes result and flags on done.

---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle arithmetic/logic ops plus iterative
// unsigned multiply and divide, with registered result, NZCV-style flags and start/ready/done.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t            state, state_next;
    logic              is_div;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CW-1:0]     count;

    logic              accept;
    logic              accept_iter;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    sub_diff;
    logic [WIDTH-1:0]  quick_result;
    logic              quick_carry;
    logic              quick_ovf;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_trial;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;

    logic              wr_en;
    logic [WIDTH-1:0]  wr_result;
    logic              wr_carry;
    logic              wr_ovf;

    assign ready       = (state != ITER);
    assign done        = (state == DONE);
    assign accept      = start && (state != ITER);
    assign accept_iter = accept && op[2] && op[1];

    always_comb begin
        add_sum      = {1'b0, A} + {1'b0, B};
        sub_diff     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        quick_result = '0;
        quick_carry  = 1'b0;
        quick_ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                quick_result = add_sum[WIDTH-1:0];
                quick_carry  = add_sum[WIDTH];
                quick_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                quick_result = sub_diff[WIDTH-1:0];
                quick_carry  = sub_diff[WIDTH];
                quick_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  quick_result = A & B;
            OP_OR:   quick_result = A | B;
            OP_XOR:  quick_result = A ^ B;
            OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: quick_result = '0;
        endcase
    end

    // One iteration: shift-add multiply keeps {hi,lo} as the partial product;
    // restoring divide keeps hi as remainder and lo as dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, b_q};
        if (!is_div) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_result = quick_result;
        wr_carry  = quick_carry;
        wr_ovf    = quick_ovf;
        if (accept && !accept_iter) begin
            wr_en = 1'b1;
        end else if (state == ITER && count == LAST) begin
            wr_en  = 1'b1;
            wr_ovf = 1'b0;
            if (!is_div) begin
                wr_result = step_lo;
                wr_carry  = |step_hi;
            end else if (b_q == '0) begin
                wr_result = '1;
                wr_carry  = 1'b1;
            end else begin
                wr_result = step_lo;
                wr_carry  = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_next = accept_iter ? ITER : DONE;
                else
                    state_next = IDLE;
            end
            ITER:    state_next = (count == LAST) ? DONE : ITER;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            b_q      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            count    <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_iter) begin
                is_div <= op[0];
                b_q    <= B;
                acc_hi <= '0;
                acc_lo <= A;
                count  <= '0;
            end else if (state == ITER) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + 1'b1;
            end
            if (wr_en) begin
                result   <= wr_result;
                zero     <= (wr_result == '0);
                carry    <= wr_carry;
                overflow <= wr_ovf;
                negative <= wr_result[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8): table of single-cycle ops,
// plus hand-written multiply/divide, back-to-back and asynchronous-reset sequences.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       negative;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op_in),
        .A        (a_in),
        .B        (b_in),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags are packed {zero, carry, overflow, negative}
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one start pulse; returns at the negedge after the sampling edge
    task automatic applyStimulus(input bit wait_first, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        if (wait_first) @(negedge clk);
        start = 1'b1;
        op_in = o;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [7:0] exp_res, input logic [3:0] exp_flags);
        checkOutput({name, "_done"}, 16'(done), 16'd1);
        checkOutput({name, "_result"}, 16'(result), 16'(exp_res));
        checkOutput({name, "_flags"}, 16'({zero, carry, overflow, negative}), 16'(exp_flags));
    endtask

    // Starts MUL/DIV, perturbs inputs and pulses an ignored ADD start during ITER
    task automatic runIterative(input string name, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] exp_res, input logic [3:0] exp_flags);
        int  cycles;
        bit  ready_low;
        @(negedge clk);
        start = 1'b1;
        op_in = o;
        a_in  = a;
        b_in  = b;
        cycles    = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles <= 8 && ready !== 1'b0) ready_low = 1'b0;
            a_in = ~a ^ 8'(cycles);
            b_in = a ^ b ^ 8'(cycles * 3);
            if (cycles == 3) begin
                start = 1'b1;
                op_in = 3'b000;
            end else begin
                start = 1'b0;
            end
        end while (done !== 1'b1 && cycles < 40);
        start = 1'b0;
        checkOutput({name, "_latency"}, 16'(cycles), 16'd9);
        checkOutput({name, "_ready_low"}, 16'(ready_low), 16'd1);
        checkResult(name, exp_res, exp_flags);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int quiet_done;
        int cycles;

        vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[2]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1100};
        vecs[3]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0001};
        vecs[4]  = '{3'b101, 8'hFE, 8'h01, 8'h01, 4'b0000};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[6]  = '{3'b011, 8'h0F, 8'hF0, 8'hFF, 4'b0001};
        vecs[7]  = '{3'b100, 8'hAA, 8'h55, 8'hFF, 4'b0001};
        vecs[8]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0110};
        vecs[9]  = '{3'b101, 8'h01, 8'hFE, 8'h00, 4'b1000};
        vecs[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1110};
        vecs[11] = '{3'b101, 8'h7F, 8'h80, 8'h00, 4'b1000};

        rst   = 1'b1;
        start = 1'b0;
        op_in = 3'b000;
        a_in  = 8'h00;
        b_in  = 8'h00;
        #1;
        checkOutput("reset_ready", 16'(ready), 16'd1);
        checkOutput("reset_done", 16'(done), 16'd0);
        checkOutput("reset_result", 16'(result), 16'h0000);
        checkOutput("reset_flags", 16'({zero, carry, overflow, negative}), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            checkResult($sformatf("vec%0d", i), vecs[i].res, vecs[i].flags);
        end

        runIterative("mul_0f_11", 3'b110, 8'h0F, 8'h11, 8'hFF, 4'b0001);
        applyStimulus(1'b0, 3'b010, 8'hF0, 8'h3C);
        checkResult("b2b_and", 8'h30, 4'b0000);
        applyStimulus(1'b0, 3'b100, 8'hAA, 8'hAA);
        checkResult("b2b_xor", 8'h00, 4'b1000);
        @(negedge clk);
        checkOutput("b2b_idle_done", 16'(done), 16'd0);

        runIterative("mul_10_10", 3'b110, 8'h10, 8'h10, 8'h00, 4'b1100);
        @(negedge clk);
        checkOutput("mul_single_done", 16'(done), 16'd0);
        checkOutput("mul_hold_result", 16'(result), 16'h0000);

        runIterative("div_c8_07", 3'b111, 8'hC8, 8'h07, 8'h1C, 4'b0000);
        runIterative("div_by_zero", 3'b111, 8'h55, 8'h00, 8'hFF, 4'b0101);

        // Asynchronous reset in the 4th ITER cycle of a multiply
        @(negedge clk);
        start = 1'b1;
        op_in = 3'b110;
        a_in  = 8'h0F;
        b_in  = 8'h11;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (cycles < 4) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("pre_rst_ready", 16'(ready), 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_ready", 16'(ready), 16'd1);
        checkOutput("async_rst_done", 16'(done), 16'd0);
        checkOutput("async_rst_result", 16'(result), 16'h0000);
        checkOutput("async_rst_flags", 16'({zero, carry, overflow, negative}), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        quiet_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0) quiet_done++;
        end
        checkOutput("no_done_after_rst", 16'(quiet_done), 16'd0);

        applyStimulus(1'b1, 3'b011, 8'h0F, 8'hF0);
        checkResult("or_after_rst", 8'hFF, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
